iter_divider: RTL and testbench

Multi-cycle, parametrised integer divider that produces one quotient bit per clock using restoring division. It adds signed/unsigned mode, divide-by-zero and signed-overflow detection, and a start/ready/valid handshake to the calculator datapath. Results are registered and held until the next accepted operation. It sits between the operand registers and the result mux in place of single-cycle combinational division.

---
 rtl/iter_divider.sv | 196 +++++++++++++++++++
 tb/tb_iter_divider.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// Multi-cycle restoring integer divider: one quotient bit per clock, signed/unsigned
// operation, divide-by-zero and signed-overflow flags, start/ready/valid handshake.
module iter_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    CNT_TOP  = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic             accept;

    logic [WIDTH-1:0] dvd_reg;
    logic [WIDTH-1:0] dvs_reg;
    logic             mode_reg;
    logic             zero_reg;

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic             sign_q;
    logic             sign_r;
    logic [WIDTH:0]   part_rem;
    logic [WIDTH-1:0] q_sh;
    logic [CW-1:0]    cnt;

    logic             dvd_neg;
    logic             dvs_neg;
    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        busy       = 1'b0;
        valid      = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    next_state = LOAD;
                end
            end
            LOAD: begin
                busy       = 1'b1;
                next_state = zero_reg ? DONE : CALC;
            end
            CALC: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    next_state = FIX;
                end
            end
            FIX: begin
                busy       = 1'b1;
                next_state = DONE;
            end
            DONE: begin
                ready = 1'b1;
                valid = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    next_state = LOAD;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Magnitudes wrap naturally: the most negative value negates to itself, which
    // reads as 2^(WIDTH-1) when treated as unsigned.
    assign dvd_neg = mode_reg & dvd_reg[WIDTH-1];
    assign dvs_neg = mode_reg & dvs_reg[WIDTH-1];
    assign dvd_abs = dvd_neg ? (~dvd_reg + 1'b1) : dvd_reg;
    assign dvs_abs = dvs_neg ? (~dvs_reg + 1'b1) : dvs_reg;

    assign shifted = {part_rem[WIDTH-1:0], dvd_mag[cnt]};
    assign trial   = shifted - {1'b0, dvs_mag};

    assign q_final = sign_q ? (~q_sh + 1'b1) : q_sh;
    assign r_final = sign_r ? (~part_rem[WIDTH-1:0] + 1'b1) : part_rem[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd_reg  <= '0;
            dvs_reg  <= '0;
            mode_reg <= 1'b0;
            zero_reg <= 1'b0;
        end else if (accept) begin
            dvd_reg  <= dividend;
            dvs_reg  <= divisor;
            mode_reg <= signed_mode;
            zero_reg <= (divisor == '0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvd_mag  <= '0;
            dvs_mag  <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            part_rem <= '0;
            q_sh     <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                LOAD: begin
                    dvd_mag  <= dvd_abs;
                    dvs_mag  <= dvs_abs;
                    sign_q   <= dvd_neg ^ dvs_neg;
                    sign_r   <= dvd_neg;
                    part_rem <= '0;
                    q_sh     <= '0;
                    cnt      <= CNT_TOP;
                end
                CALC: begin
                    // Restoring step: keep the subtraction only when it does not go negative.
                    if (!trial[WIDTH]) begin
                        part_rem  <= trial;
                        q_sh[cnt] <= 1'b1;
                    end else begin
                        part_rem <= shifted;
                    end
                    cnt <= cnt - 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (accept) begin
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else if (state == LOAD && zero_reg) begin
            quotient    <= ALL_ONES;
            remainder   <= dvd_reg;
            div_by_zero <= 1'b1;
        end else if (state == FIX) begin
            quotient  <= q_final;
            remainder <= r_final;
            overflow  <= mode_reg && (dvd_reg == MOST_NEG) && (dvs_reg == ALL_ONES);
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Randomised scoreboard bench for iter_divider: stimulus pushes expected results
// computed with plain integer arithmetic; a monitor pops them on every valid pulse.
module tb_iter_divider;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic         signed_mode;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         ready;
    logic         busy;
    logic         valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    iter_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .ready       (ready),
        .busy        (busy),
        .valid       (valid),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input int e);
        exp_t x;
        int   sa;
        int   sbv;
        if (b == 0) begin
            x.q   = '1;
            x.r   = a;
            x.dz  = 1'b1;
            x.ov  = 1'b0;
            x.cyc = e + 1;
        end else begin
            if (sm) begin
                sa   = $signed(a);
                sbv  = $signed(b);
                x.q  = W'(sa / sbv);
                x.r  = W'(sa % sbv);
                x.ov = (sa == -(1 << (W - 1))) && (sbv == -1);
            end else begin
                x.q  = a / b;
                x.r  = a % b;
                x.ov = 1'b0;
            end
            x.dz  = 1'b0;
            x.cyc = e + W + 2;
        end
        return x;
    endfunction

    // Waits for ready on a falling edge, then presents one start for a single cycle.
    task automatic applyStimulus(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checkOutput("ready_timeout", 32'(ready), 32'd1);
        end else begin
            signed_mode = sm;
            dividend    = a;
            divisor     = b;
            start       = 1'b1;
            sb.push_back(model(sm, a, b, cyc + 1));
            @(posedge clk);
            #1 start = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        if (rst && valid) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_valid", 32'(valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("quotient", 32'(quotient), 32'(e.q));
                checkOutput("remainder", 32'(remainder), 32'(e.r));
                checkOutput("div_by_zero", 32'(div_by_zero), 32'(e.dz));
                checkOutput("overflow", 32'(overflow), 32'(e.ov));
                checkOutput("latency", 32'(cyc), 32'(e.cyc));
                checkOutput("ready_in_done", 32'(ready), 32'd1);
                checkOutput("busy_in_done", 32'(busy), 32'd0);
            end
        end
    end

    initial begin
        rst         = 1'b0;
        start       = 1'b0;
        signed_mode = 1'b0;
        dividend    = '0;
        divisor     = '0;
        #12;
        checkOutput("reset_ready", 32'(ready), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_valid", 32'(valid), 32'd0);
        checkOutput("reset_quotient", 32'(quotient), 32'd0);
        checkOutput("reset_remainder", 32'(remainder), 32'd0);
        checkOutput("reset_dz", 32'(div_by_zero), 32'd0);
        checkOutput("reset_ov", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        $display("[TB] unsigned 200/7 with busy tracking");
        applyStimulus(1'b0, 8'd200, 8'd7);
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            checkOutput("busy_inflight", 32'(busy), 32'd1);
        end

        $display("[TB] signed, divide by zero, overflow");
        applyStimulus(1'b1, 8'hF9, 8'h02);
        applyStimulus(1'b1, 8'h07, 8'hFE);
        applyStimulus(1'b0, 8'h55, 8'h00);
        applyStimulus(1'b1, 8'h55, 8'h00);
        applyStimulus(1'b1, 8'h80, 8'hFF);
        applyStimulus(1'b0, 8'h80, 8'hFF);

        $display("[TB] handshake: ignored start, back-to-back start");
        applyStimulus(1'b0, 8'd99, 8'd10);
        repeat (3) @(negedge clk);
        signed_mode = 1'b1;
        dividend    = 8'd17;
        divisor     = 8'd3;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        applyStimulus(1'b0, 8'd250, 8'd9);
        applyStimulus(1'b1, 8'h81, 8'h05);

        $display("[TB] asynchronous reset mid-operation");
        applyStimulus(1'b0, 8'd100, 8'd3);
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_rst_quotient", 32'(quotient), 32'd0);
        checkOutput("async_rst_remainder", 32'(remainder), 32'd0);
        checkOutput("async_rst_valid", 32'(valid), 32'd0);
        checkOutput("async_rst_ready", 32'(ready), 32'd1);
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(1'b0, 8'd255, 8'd16);

        $display("[TB] randomised operations");
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'($urandom);
            b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                a = 8'h80;
                b = 8'hFF;
            end
            applyStimulus(1'($urandom), a, b);
        end

        for (int n = 0; n < 200 && sb.size() != 0; n++) begin
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
